// File: rtl/e_mdu_if.sv
// e_mdu_if: request/result bundle between the pipeline and the multiply/divide unit
interface e_mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       mdOp;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, mdOp, in1, in2, input busy, hi, lo);
  modport slave(input start, mdOp, in1, in2, output busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: MIPS-style HI/LO multiply/divide unit with fixed-latency busy window
module e_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t r_state, w_state;
  logic [3:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_phi, r_plo, w_hi, w_lo, w_phi, w_plo;
  logic [WIDTH-1:0] w_dsr, w_qs, w_rs, w_qu, w_ru;
  logic [2*WIDTH-1:0] w_ps, w_pu, w_div, w_res;
  logic w_mul, w_dv, w_zero, w_ovf;
  assign w_mul  = bus.mdOp[2:1] == 2'b00;
  assign w_dv   = bus.mdOp[2:1] == 2'b01;
  assign w_zero = bus.in2 == '0;
  assign w_ovf  = !bus.mdOp[0] && bus.in1 == MIN && &bus.in2;
  assign w_ps   = {{WIDTH{bus.in1[WIDTH-1]}}, bus.in1} * {{WIDTH{bus.in2[WIDTH-1]}}, bus.in2};
  assign w_pu   = {{WIDTH{1'b0}}, bus.in1} * {{WIDTH{1'b0}}, bus.in2};
  // divide-by-zero and MIN/-1 are answered without the divider, so feed it a harmless divisor
  assign w_dsr  = (w_zero || w_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.in2;
  assign w_qs   = $signed(bus.in1) / $signed(w_dsr);
  assign w_rs   = $signed(bus.in1) % $signed(w_dsr);
  assign w_qu   = bus.in1 / w_dsr;
  assign w_ru   = bus.in1 % w_dsr;
  assign w_div  = w_zero ? {r_hi, r_lo} : w_ovf ? {{WIDTH{1'b0}}, MIN} :
                  bus.mdOp[0] ? {w_ru, w_qu} : {w_rs, w_qs};
  assign w_res  = w_mul ? (bus.mdOp[0] ? w_pu : w_ps) : w_div;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_hi    = r_hi;
    w_lo    = r_lo;
    w_phi   = r_phi;
    w_plo   = r_plo;
    if (r_state == RUN) begin
      w_cnt = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        w_state = IDLE;
        w_hi    = r_phi;
        w_lo    = r_plo;
      end
    end else if (bus.start) begin
      if (w_mul || w_dv) begin
        w_state      = RUN;
        w_cnt        = w_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        {w_phi, w_plo} = w_res;
      end
      w_hi = bus.mdOp == 3'b100 ? bus.in1 : r_hi;
      w_lo = bus.mdOp == 3'b101 ? bus.in1 : r_lo;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_hi    <= w_hi;
      r_lo    <= w_lo;
      r_phi   <= w_phi;
      r_plo   <= w_plo;
    end
  end
  assign bus.busy = r_state == RUN;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu with a plain-arithmetic HI/LO reference model
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;
  localparam logic [31:0] MIN = 32'h8000_0000;
  typedef struct {
    int          kind;
    logic [31:0] pre_hi, pre_lo, hi, lo;
    int          cyc;
  } exp_t;
  logic clk, reset;
  e_mdu_if #(.WIDTH(32)) bus();
  e_mdu #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut(.clk(clk), .reset(reset), .bus(bus));
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, failures = 0, bcnt = 0;
  bit mon_busy = 0, acc_mt = 0, rst_seen = 0;
  logic [31:0] m_hi, m_lo;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] cur);
    longint sa, sb, qq, rr;
    logic [63:0] ua, ub, uq, ur, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = cur;
    if (op == 3'd0) r = sa * sb;
    else if (op == 3'd1) r = ua * ub;
    else if (op == 3'd2 && b != 0) begin
      qq = sa / sb;
      rr = sa % sb;
      r  = {rr[31:0], qq[31:0]};
    end else if (op == 3'd3 && b != 0) begin
      uq = ua / ub;
      ur = ua % ub;
      r  = {ur[31:0], uq[31:0]};
    end
    return r;
  endfunction
  function automatic logic [31:0] rnd_val();
    int s = $urandom_range(0, 7);
    return s == 0 ? 32'd0 : s == 1 ? 32'd1 : s == 2 ? 32'hFFFF_FFFF : s == 3 ? MIN :
           s == 4 ? 32'h7FFF_FFFF : $urandom;
  endfunction
  // observe acceptance of MTHI/MTLO and reset at the edge they take effect
  always @(posedge clk) begin
    rst_seen <= reset;
    acc_mt   <= !reset && bus.start && !bus.busy && (bus.mdOp == 3'd4 || bus.mdOp == 3'd5);
  end
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      bcnt = 0;
    end else if (reset) begin
    end else if (acc_mt) begin
      if (q.size() == 0) chk("mt_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = q.pop_front();
        chk("mt_kind", 64'(mon_e.kind), 64'd1);
        chk("mt_hilo", {bus.hi, bus.lo}, {mon_e.hi, mon_e.lo});
        chk("mt_busy", 64'(bus.busy), 64'd0);
      end
    end else if (bus.busy) begin
      bcnt++;
      if (q.size() == 0) chk("busy_unexpected", 64'd1, 64'd0);
      else chk("hold_hilo", {bus.hi, bus.lo}, {q[0].pre_hi, q[0].pre_lo});
    end else if (mon_busy) begin
      if (q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = q.pop_front();
        chk("done_kind", 64'(mon_e.kind), 64'd0);
        chk("done_hilo", {bus.hi, bus.lo}, {mon_e.hi, mon_e.lo});
        chk("busy_cycles", 64'(bcnt), 64'(mon_e.cyc));
      end
      bcnt = 0;
    end
    mon_busy = bus.busy && !rst_seen && !reset;
  end
  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1;
    bus.mdOp  = op;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk);
    #1;
    bus.start = 0;
    bus.mdOp  = 3'($urandom);
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.pre_hi = m_hi;
    e.pre_lo = m_lo;
    e.kind   = op <= 3'd3 ? 0 : 1;
    e.cyc    = op <= 3'd1 ? MC : op <= 3'd3 ? DC : 0;
    if (op <= 3'd3) {m_hi, m_lo} = ref_res(op, a, b, {m_hi, m_lo});
    else if (op == 3'd4) m_hi = a;
    else if (op == 3'd5) m_lo = a;
    e.hi = m_hi;
    e.lo = m_lo;
    if (op <= 3'd5) q.push_back(e);
    pulse(op, a, b);
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int nign);
    int n;
    issue(op, a, b);
    if (op <= 3'd3) begin
      n = op <= 3'd1 ? MC : DC;
      for (int i = 0; i < nign; i++) pulse(3'($urandom), rnd_val(), rnd_val());
      repeat (n - nign) @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1;
    q.delete();
    m_hi = 0;
    m_lo = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask
  initial begin
    bus.start = 0;
    bus.mdOp  = 0;
    bus.in1   = 0;
    bus.in2   = 0;
    reset     = 1;
    @(posedge clk);
    #1;
    do_reset();
    run(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    run(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    run(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run(3'd2, MIN, 32'hFFFF_FFFF, 0);
    run(3'd4, 32'h1234_5678, 32'd0, 0);
    run(3'd3, 32'd77, 32'd0, 0);
    issue(3'd0, 32'd1234, 32'hFFFF_0000);
    pulse(3'd5, 32'h0000_AAAA, 32'd0);
    pulse(3'd0, 32'd5, 32'd6);
    repeat (MC - 2) @(posedge clk);
    #1;
    run(3'd6, 32'hDEAD_BEEF, 32'd1, 0);
    run(3'd7, 32'hDEAD_BEEF, 32'd1, 0);
    run(3'd5, 32'h5555_0001, 32'd0, 0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    q.delete();
    m_hi = 0;
    m_lo = 0;
    @(posedge clk);
    #1;
    reset = 0;
    repeat (DC + 4) @(posedge clk);
    #1;
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run(op, rnd_val(), rnd_val(), op <= 3'd3 ? $urandom_range(0, 3) : 0);
    end
    repeat (20) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
